// File: rtl/des_pkg.sv
// Shared DES controller types, widths and key-schedule tables.
// Holds the per-round shift table, the PC2 selection table and the 28-bit rotate helpers.
// Purely declarative; no logic or timing of its own.
package des_pkg;

  localparam int HALF_W = 32;
  localparam int KEYH_W = 28;
  localparam int RK_W   = 48;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Left-rotate amount applied to C and D in encrypt round i.
  localparam logic [1:0] SH [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // PC2: output bit n (1 = MSB) takes input bit PC2_TBL[n-1] of the 56-bit {C,D} (1 = MSB).
  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [KEYH_W-1:0] rotl28(input logic [KEYH_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[KEYH_W-2:0], x[KEYH_W-1]};
      2'd2:    return {x[KEYH_W-3:0], x[KEYH_W-1:KEYH_W-2]};
      default: return x;
    endcase
  endfunction

  function automatic logic [KEYH_W-1:0] rotr28(input logic [KEYH_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[KEYH_W-1:1]};
      2'd2:    return {x[1:0], x[KEYH_W-1:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/key_pc2.sv
// PC2 key compression: selects 48 of the 56 {C,D} bits to form a round key.
// Latency: combinational, zero cycles.
// Backpressure: none; pure wiring.
module key_pc2
  import des_pkg::*;
(
  input  logic [2*KEYH_W-1:0] i_cd,
  output logic [RK_W-1:0]     o_k
);

  for (genvar i = 0; i < RK_W; i++) begin : g_sel
    assign o_k[RK_W-1-i] = i_cd[6'(2*KEYH_W - PC2_TBL[i])];
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: drives an external Feistel round 16 times and builds each round key.
// Latency: request accepted at edge 0, rsp_valid rises after edge 17; one idle cycle before the next accept.
// Backpressure: rsp_* held stable until rsp_ready; req_ready low from accept until the response is taken.
// Build option DES_DECRYPT_EN: when defined, req_dec selects the reverse key schedule; otherwise encrypt only.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int NROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [HALF_W-1:0] req_l,
  input  logic [HALF_W-1:0] req_r,
  input  logic [KEYH_W-1:0] req_c,
  input  logic [KEYH_W-1:0] req_d,
  input  logic              req_dec,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [HALF_W-1:0] rsp_l,
  output logic [HALF_W-1:0] rsp_r,
  output logic [HALF_W-1:0] round_xl,
  output logic [HALF_W-1:0] round_xr,
  output logic [RK_W-1:0]   round_k,
  input  logic [HALF_W-1:0] round_rl,
  input  logic [HALF_W-1:0] round_rr
);

  localparam int CNT_W = $clog2(NROUNDS);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [HALF_W-1:0]   r_l;
  logic [HALF_W-1:0]   r_r;
  logic [KEYH_W-1:0]   r_c;
  logic [KEYH_W-1:0]   r_d;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [HALF_W-1:0]   r_rsp_l;
  logic [HALF_W-1:0]   r_rsp_r;
  logic [KEYH_W-1:0]   w_c_nxt;
  logic [KEYH_W-1:0]   w_d_nxt;

`ifdef DES_DECRYPT_EN
  logic                r_dec;
  logic [CNT_W-1:0]    w_dec_idx;
  // Decrypt walks the encrypt schedule backwards: round i undoes encrypt shift NROUNDS-i.
  assign w_dec_idx = CNT_W'(NROUNDS - int'(r_cnt));
`else
  logic                w_unused_dec;
  assign w_unused_dec = req_dec;
`endif

  // Next key halves: rotated while running, otherwise the held C/D so round_k stays defined.
  always_comb begin
    w_c_nxt = r_c;
    w_d_nxt = r_d;
    if (r_state == RUN) begin
`ifdef DES_DECRYPT_EN
      if (r_dec) begin
        // Round 0 of decrypt uses C0D0 directly, which equals C16D16.
        if (r_cnt != '0) begin
          w_c_nxt = rotr28(r_c, SH[w_dec_idx]);
          w_d_nxt = rotr28(r_d, SH[w_dec_idx]);
        end
      end else begin
        w_c_nxt = rotl28(r_c, SH[r_cnt]);
        w_d_nxt = rotl28(r_d, SH[r_cnt]);
      end
`else
      w_c_nxt = rotl28(r_c, SH[r_cnt]);
      w_d_nxt = rotl28(r_d, SH[r_cnt]);
`endif
    end
  end

  key_pc2 u_key_pc2 (
    .i_cd ({w_c_nxt, w_d_nxt}),
    .o_k  (round_k)
  );

  assign round_xl  = r_l;
  assign round_xr  = r_r;
  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_l     = r_rsp_l;
  assign rsp_r     = r_rsp_r;

  // Control FSM: accept, iterate rounds, present result with the final swap, wait for acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_l     <= '0;
      r_rsp_r     <= '0;
`ifdef DES_DECRYPT_EN
      r_dec       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_l         <= req_l;
            r_r         <= req_r;
            r_c         <= req_c;
            r_d         <= req_d;
`ifdef DES_DECRYPT_EN
            r_dec       <= req_dec;
`endif
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          r_l   <= round_rl;
          r_r   <= round_rr;
          r_c   <= w_c_nxt;
          r_d   <= w_d_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(NROUNDS - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!r_rsp_valid) begin
            // Final swap: the block leaves as (R16, L16).
            r_rsp_valid <= 1'b1;
            r_rsp_l     <= r_r;
            r_rsp_r     <= r_l;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: hosts the DES round function and a full-cipher reference model.
// Transactions are observed by a negedge monitor that logs accept/response cycles and data.
// Build option DES_DECRYPT_EN changes which result the decrypt-flagged vectors expect.
module tb_des_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_dec;
  logic [31:0] req_l, req_r;
  logic [27:0] req_c, req_d;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_l, rsp_r;
  logic [31:0] round_xl, round_xr, round_rl, round_rr;
  logic [47:0] round_k;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [31:0] l, r;
    logic [27:0] c, d;
    logic        dec;
    logic [31:0] el, er;
    logic [47:0] ek;
  } vec_t;

  localparam int SH_M [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam int PC2_M [48] = '{
    14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int E_T [48] = '{
    32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{
    16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int SBOX [512] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

  // DES f(R,K): expand, key mix, S-boxes, permute.
  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s, p;
    logic [5:0]  b;
    int          idx;
    s = '0;
    for (int i = 0; i < 48; i++) e[47-i] = r[5'(32 - E_T[i])];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b   = 6'(e >> (42 - 6*j));
      idx = j*64 + int'({b[5], b[0]})*16 + int'(b[4:1]);
      s   = {s[27:0], 4'(SBOX[idx])};
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[5'(32 - P_T[i])];
    return p;
  endfunction

  function automatic logic [47:0] pc2_m(input logic [55:0] cd);
    logic [47:0] k;
    for (int i = 0; i < 48; i++) k[47-i] = cd[6'(56 - PC2_M[i])];
    return k;
  endfunction

  function automatic logic [27:0] rotl_m(input logic [27:0] x, input int n);
    return (x << n) | (x >> (28 - n));
  endfunction

  // Whole-cipher model: precompute K1..K16, use them reversed for decrypt, run 16 rounds, swap.
  function automatic void model(input vec_t v, output logic [63:0] res, output logic [47:0] k0);
    logic [47:0] ks [16];
    logic [47:0] k;
    logic [27:0] c, d;
    logic [31:0] l, r, t;
    logic        dec_eff;
`ifdef DES_DECRYPT_EN
    dec_eff = v.dec;
`else
    dec_eff = 1'b0;
`endif
    c = v.c; d = v.d; l = v.l; r = v.r; k0 = '0;
    for (int i = 0; i < 16; i++) begin
      c = rotl_m(c, SH_M[i]);
      d = rotl_m(d, SH_M[i]);
      ks[i] = pc2_m({c, d});
    end
    for (int i = 0; i < 16; i++) begin
      k = dec_eff ? ks[15-i] : ks[i];
      if (i == 0) k0 = k;
      t = r;
      r = l ^ f_fn(r, k);
      l = t;
    end
    res = {r, l};
  endfunction

  // Round datapath the controller is built to drive.
  always_comb begin
    round_rl = round_xr;
    round_rr = round_xl ^ f_fn(round_xr, round_k);
  end

  des_round_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_l(req_l), .req_r(req_r), .req_c(req_c), .req_d(req_d), .req_dec(req_dec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_l(rsp_l), .rsp_r(rsp_r),
    .round_xl(round_xl), .round_xr(round_xr), .round_k(round_k),
    .round_rl(round_rl), .round_rr(round_rr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Handshake log; a negedge with valid&ready means the transfer happens on the next rising edge.
  int          acc_q [$];
  int          rspc_q [$];
  logic [63:0] rsp_q [$];
  logic [47:0] k0_q [$];
  bit          k0_pend = 1'b0;

  always @(negedge clk) begin
    if (k0_pend) begin
      k0_q.push_back(round_k);
      k0_pend = 1'b0;
    end
    if (rst_n && req_valid && req_ready) begin
      acc_q.push_back(cyc);
      k0_pend = 1'b1;
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_q.push_back({rsp_l, rsp_r});
      rspc_q.push_back(cyc);
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic clear_log();
    acc_q.delete(); rspc_q.delete(); rsp_q.delete(); k0_q.delete();
  endtask

  task automatic drive(input vec_t v);
    req_l = v.l; req_r = v.r; req_c = v.c; req_d = v.d; req_dec = v.dec;
  endtask

  task automatic wait_acc(input int n, input string nm);
    int t = 0;
    while (acc_q.size() < n && t < 80) begin @(posedge clk); #1; t++; end
    if (acc_q.size() < n) check({nm, "_accept_timeout"}, 64'(acc_q.size()), 64'(n));
  endtask

  task automatic wait_rsp(input int n, input string nm);
    int t = 0;
    while (rsp_q.size() < n && t < 80) begin @(posedge clk); #1; t++; end
    if (rsp_q.size() < n) check({nm, "_rsp_timeout"}, 64'(rsp_q.size()), 64'(n));
  endtask

  // One request with rsp_ready held high; reports result, first round key and edges to rsp_valid.
  task automatic xact(input vec_t v, input string nm, output logic [63:0] res,
                      output logic [47:0] k0, output int lat);
    clear_log();
    rsp_ready = 1'b1;
    drive(v);
    req_valid = 1'b1;
    wait_acc(1, nm);
    req_valid = 1'b0;
    wait_rsp(1, nm);
    res = 'x; k0 = 'x; lat = -1;
    if (rsp_q.size() > 0 && acc_q.size() > 0 && k0_q.size() > 0) begin
      res = rsp_q[0];
      k0  = k0_q[0];
      lat = rspc_q[0] - acc_q[0] - 1;
    end
  endtask

  vec_t        tbl [2];
  vec_t        v, vb;
  logic [63:0] res, exp_res, snap;
  logic [47:0] k0, exp_k0;
  int          lat;
  int          t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{l:32'hCC00CCFF, r:32'hF0AAF0AA, c:28'hF0CCAAF, d:28'h556678F, dec:1'b0,
               el:32'h0A4CD995, er:32'h43423234, ek:48'h1B02EFFC7072};
`ifdef DES_DECRYPT_EN
    tbl[1] = '{l:32'h0A4CD995, r:32'h43423234, c:28'hF0CCAAF, d:28'h556678F, dec:1'b1,
               el:32'hCC00CCFF, er:32'hF0AAF0AA, ek:48'hCB3D8B0E17F5};
`else
    tbl[1] = '{l:32'hCC00CCFF, r:32'hF0AAF0AA, c:28'hF0CCAAF, d:28'h556678F, dec:1'b1,
               el:32'h0A4CD995, er:32'h43423234, ek:48'h1B02EFFC7072};
`endif
    req_valid = 1'b0; rsp_ready = 1'b0;
    drive(tbl[0]);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_l", 64'(rsp_l), 64'd0);
    check("rst_rsp_r", 64'(rsp_r), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Known vectors
    for (int i = 0; i < 2; i++) begin
      xact(tbl[i], "tbl", res, k0, lat);
      check($sformatf("tbl%0d_rsp_l", i), 64'(res[63:32]), 64'(tbl[i].el));
      check($sformatf("tbl%0d_rsp_r", i), 64'(res[31:0]), 64'(tbl[i].er));
      check($sformatf("tbl%0d_k0", i), 64'(k0), 64'(tbl[i].ek));
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd17);
    end

    // Random vectors against the model
    for (int i = 0; i < 12; i++) begin
      v.l = $urandom; v.r = $urandom;
      v.c = 28'($urandom); v.d = 28'($urandom);
      v.dec = 1'($urandom_range(0, 1));
      v.el = '0; v.er = '0; v.ek = '0;
      model(v, exp_res, exp_k0);
      xact(v, "rnd", res, k0, lat);
      check($sformatf("rnd%0d_rsp", i), res, exp_res);
      check($sformatf("rnd%0d_k0", i), 64'(k0), 64'(exp_k0));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd17);
    end

    // Back-pressure: response held, competing request ignored until return to IDLE
    clear_log();
    rsp_ready = 1'b0;
    drive(tbl[0]);
    req_valid = 1'b1;
    wait_acc(1, "bp");
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 40) begin @(posedge clk); #1; t++; end
    check("bp_rsp_valid_seen", 64'(rsp_valid), 64'd1);
    snap = {rsp_l, rsp_r};
    check("bp_first_rsp", snap, {tbl[0].el, tbl[0].er});
    vb.l = $urandom; vb.r = $urandom; vb.c = 28'($urandom); vb.d = 28'($urandom);
    vb.dec = 1'b0; vb.el = '0; vb.er = '0; vb.ek = '0;
    drive(vb);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {31'd0, rsp_valid, rsp_l, rsp_r}, {31'd0, 1'b1, snap});
      check($sformatf("bp_req_ready%0d", i), 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1;
    check("bp_req_ignored", 64'(acc_q.size()), 64'd1);
    rsp_ready = 1'b1;
    wait_acc(2, "bp");
    req_valid = 1'b0;
    wait_rsp(2, "bp");
    model(vb, exp_res, exp_k0);
    if (rsp_q.size() >= 2 && acc_q.size() >= 2) begin
      check("bp_rsp0", rsp_q[0], {tbl[0].el, tbl[0].er});
      check("bp_rsp1", rsp_q[1], exp_res);
      check("bp_idle_gap", 64'(acc_q[1] - rspc_q[0]), 64'd1);
    end

    // Reset in the middle of a run
    clear_log();
    rsp_ready = 1'b1;
    drive(tbl[0]);
    req_valid = 1'b1;
    wait_acc(1, "rst");
    req_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("midrst_nothing_emitted", 64'(rsp_q.size()), 64'd0);
    check("midrst_rsp_valid_low", 64'(rsp_valid), 64'd0);
    xact(tbl[0], "postrst", res, k0, lat);
    check("postrst_rsp", res, {tbl[0].el, tbl[0].er});
    check("postrst_latency", 64'(lat), 64'd17);

    // Back-to-back requests with rsp_ready held high
    clear_log();
    rsp_ready = 1'b1;
    drive(tbl[0]);
    req_valid = 1'b1;
    wait_acc(2, "b2b");
    req_valid = 1'b0;
    wait_rsp(2, "b2b");
    if (rsp_q.size() >= 2 && acc_q.size() >= 2) begin
      check("b2b_rsp0", rsp_q[0], {tbl[0].el, tbl[0].er});
      check("b2b_rsp1", rsp_q[1], {tbl[0].el, tbl[0].er});
      check("b2b_gap", 64'(acc_q[1] - rspc_q[0]), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
